// File: rtl/vector_chip_pkg.sv
// Shared scalar-datapath definitions: register file geometry, the writeback
// request record and a small index decode helper.
package vector_chip_pkg;

  localparam int SCALAR_REG_WIDTH = 64;
  localparam int SCALAR_REG_DEPTH = 32;
  localparam int SCALAR_IDX_WIDTH = 5;

  // One writeback: target file, destination index and result value.
  typedef struct packed {
    logic                        fp;
    logic [SCALAR_IDX_WIDTH-1:0] rd;
    logic [SCALAR_REG_WIDTH-1:0] data;
  } wb_req_t;

  // Decode a register index into a one-hot scoreboard mask.
  function automatic logic [SCALAR_REG_DEPTH-1:0] idx_to_onehot(
    input logic [SCALAR_IDX_WIDTH-1:0] idx
  );
    logic [SCALAR_REG_DEPTH-1:0] oh;
    oh      = {SCALAR_REG_DEPTH{1'b0}};
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/scalar_wb_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester found when
// searching upward from the pointer, wrapping modulo N. Pointer storage and
// update live in the caller so one instance serves each register domain.
module rr_arbiter #(
  parameter int N     = 3,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt
);

  // Walk offsets 0..N-1 from the pointer; the first requesting slot wins.
  always_comb begin
    logic found_s;
    logic hit_s;
    gnt     = {N{1'b0}};
    found_s = 1'b0;
    hit_s   = 1'b0;
    for (int k = 0; k < N; k++) begin
      for (int j = 0; j < N; j++) begin
        hit_s   = !found_s && req[j] && (j == ((int'(ptr) + k) % N));
        gnt[j]  = gnt[j] | hit_s;
        found_s = found_s | hit_s;
      end
    end
  end

endmodule

// File: rtl/scalar_wb_arbiter.sv
// Scalar writeback arbiter: merges NUM_SRC result sources onto one integer
// and one FP register-file write port (independent round-robin per domain),
// and keeps a pending-write scoreboard used to stall issue on busy targets.
// Optional build macro SCALAR_WB_BYPASS_EN adds same-cycle forwarding
// outputs carrying the granted results one cycle ahead of the write.
module scalar_wb_arbiter
  import vector_chip_pkg::*;
#(
  parameter int NUM_SRC    = 3,
  parameter int RR_EN_INIT = 0
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic [NUM_SRC-1:0]                        src_valid,
  input  logic [NUM_SRC-1:0]                        src_fp,
  input  logic [NUM_SRC-1:0][SCALAR_IDX_WIDTH-1:0]  src_rd,
  input  logic [NUM_SRC-1:0][SCALAR_REG_WIDTH-1:0]  src_data,
  output logic [NUM_SRC-1:0]                        src_ready,
  output logic                                      write,
  output logic [SCALAR_IDX_WIDTH-1:0]               wr_access_ptr,
  output logic [SCALAR_REG_WIDTH-1:0]               write_data,
  output logic                                      fwrite,
  output logic [SCALAR_IDX_WIDTH-1:0]               wr_faccess_ptr,
  output logic [SCALAR_REG_WIDTH-1:0]               fwrite_data,
  input  logic                                      issue_valid,
  input  logic                                      issue_fp,
  input  logic [SCALAR_IDX_WIDTH-1:0]               issue_rd,
  output logic                                      issue_stall,
`ifdef SCALAR_WB_BYPASS_EN
  output logic [1:0]                                byp_valid,
  output logic [1:0]                                byp_fp,
  output logic [1:0][SCALAR_IDX_WIDTH-1:0]          byp_rd,
  output logic [1:0][SCALAR_REG_WIDTH-1:0]          byp_data,
`endif
  output logic [SCALAR_REG_DEPTH-1:0]               busy_int,
  output logic [SCALAR_REG_DEPTH-1:0]               busy_fp
);

  localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [PTR_W-1:0] PTR_INIT = PTR_W'(RR_EN_INIT);

  logic [NUM_SRC-1:0]          req_int_s;
  logic [NUM_SRC-1:0]          req_fp_s;
  logic [NUM_SRC-1:0]          gnt_int_s;
  logic [NUM_SRC-1:0]          gnt_fp_s;
  logic                        int_any_s;
  logic                        fp_any_s;
  logic [PTR_W-1:0]            ptr_int_r;
  logic [PTR_W-1:0]            ptr_fp_r;
  wb_req_t                     int_sel_s;
  wb_req_t                     fp_sel_s;
  logic                        write_r;
  logic [SCALAR_IDX_WIDTH-1:0] wr_ptr_r;
  logic [SCALAR_REG_WIDTH-1:0] wr_data_r;
  logic                        fwrite_r;
  logic [SCALAR_IDX_WIDTH-1:0] fwr_ptr_r;
  logic [SCALAR_REG_WIDTH-1:0] fwr_data_r;
  logic [SCALAR_REG_DEPTH-1:0] busy_int_r;
  logic [SCALAR_REG_DEPTH-1:0] busy_fp_r;
  logic                        stall_s;
  logic                        accept_s;
  logic [SCALAR_REG_DEPTH-1:0] set_int_s;
  logic [SCALAR_REG_DEPTH-1:0] set_fp_s;
  logic [SCALAR_REG_DEPTH-1:0] clr_int_s;
  logic [SCALAR_REG_DEPTH-1:0] clr_fp_s;

  // Index of the single set bit of a grant vector.
  function automatic logic [PTR_W-1:0] onehot_to_idx(input logic [NUM_SRC-1:0] oh);
    logic [PTR_W-1:0] idx;
    idx = {PTR_W{1'b0}};
    for (int i = 0; i < NUM_SRC; i++) begin
      idx = idx | ({PTR_W{oh[i]}} & PTR_W'(i));
    end
    return idx;
  endfunction

  // Slot after the winner, wrapping back to source 0.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] win);
    logic [PTR_W-1:0] nxt;
    if (win == PTR_W'(NUM_SRC - 1)) begin
      nxt = {PTR_W{1'b0}};
    end else begin
      nxt = win + PTR_W'(1);
    end
    return nxt;
  endfunction

  // Requests are masked during reset so no source sees a grant whose result
  // would be discarded.
  assign req_int_s = src_valid & ~src_fp & {NUM_SRC{~reset}};
  assign req_fp_s  = src_valid &  src_fp & {NUM_SRC{~reset}};

  rr_arbiter #(.N(NUM_SRC), .PTR_W(PTR_W)) u_arb_int (
    .req (req_int_s),
    .ptr (ptr_int_r),
    .gnt (gnt_int_s)
  );

  rr_arbiter #(.N(NUM_SRC), .PTR_W(PTR_W)) u_arb_fp (
    .req (req_fp_s),
    .ptr (ptr_fp_r),
    .gnt (gnt_fp_s)
  );

  assign src_ready = gnt_int_s | gnt_fp_s;
  assign int_any_s = |gnt_int_s;
  assign fp_any_s  = |gnt_fp_s;

  // Steer the granted source of each domain through an AND-OR mux.
  always_comb begin
    int_sel_s      = {$bits(wb_req_t){1'b0}};
    fp_sel_s       = {$bits(wb_req_t){1'b0}};
    int_sel_s.fp   = 1'b0;
    fp_sel_s.fp    = 1'b1;
    for (int i = 0; i < NUM_SRC; i++) begin
      int_sel_s.rd   = int_sel_s.rd   | ({SCALAR_IDX_WIDTH{gnt_int_s[i]}} & src_rd[i]);
      int_sel_s.data = int_sel_s.data | ({SCALAR_REG_WIDTH{gnt_int_s[i]}} & src_data[i]);
      fp_sel_s.rd    = fp_sel_s.rd    | ({SCALAR_IDX_WIDTH{gnt_fp_s[i]}}  & src_rd[i]);
      fp_sel_s.data  = fp_sel_s.data  | ({SCALAR_REG_WIDTH{gnt_fp_s[i]}}  & src_data[i]);
    end
  end

  // Advance each domain's pointer past its winner; hold when nothing granted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_int_r <= PTR_INIT;
      ptr_fp_r  <= PTR_INIT;
    end else begin
      if (int_any_s) begin
        ptr_int_r <= next_ptr(onehot_to_idx(gnt_int_s));
      end
      if (fp_any_s) begin
        ptr_fp_r <= next_ptr(onehot_to_idx(gnt_fp_s));
      end
    end
  end

  // Register the granted results onto the two register-file write ports.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_r    <= 1'b0;
      wr_ptr_r   <= {SCALAR_IDX_WIDTH{1'b0}};
      wr_data_r  <= {SCALAR_REG_WIDTH{1'b0}};
      fwrite_r   <= 1'b0;
      fwr_ptr_r  <= {SCALAR_IDX_WIDTH{1'b0}};
      fwr_data_r <= {SCALAR_REG_WIDTH{1'b0}};
    end else begin
      write_r  <= int_any_s;
      fwrite_r <= fp_any_s;
      if (int_any_s) begin
        wr_ptr_r  <= int_sel_s.rd;
        wr_data_r <= int_sel_s.data;
      end
      if (fp_any_s) begin
        fwr_ptr_r  <= fp_sel_s.rd;
        fwr_data_r <= fp_sel_s.data;
      end
    end
  end

  assign write          = write_r;
  assign wr_access_ptr  = wr_ptr_r;
  assign write_data     = wr_data_r;
  assign fwrite         = fwrite_r;
  assign wr_faccess_ptr = fwr_ptr_r;
  assign fwrite_data    = fwr_data_r;

  // Scoreboard set/clear masks: a reservation sets, the cycle's commit clears.
  always_comb begin
    stall_s   = issue_valid & (issue_fp ? busy_fp_r[issue_rd] : busy_int_r[issue_rd]);
    accept_s  = issue_valid & ~stall_s;
    set_int_s = (accept_s & ~issue_fp) ? idx_to_onehot(issue_rd) : {SCALAR_REG_DEPTH{1'b0}};
    set_fp_s  = (accept_s &  issue_fp) ? idx_to_onehot(issue_rd) : {SCALAR_REG_DEPTH{1'b0}};
    clr_int_s = write_r  ? idx_to_onehot(wr_ptr_r)  : {SCALAR_REG_DEPTH{1'b0}};
    clr_fp_s  = fwrite_r ? idx_to_onehot(fwr_ptr_r) : {SCALAR_REG_DEPTH{1'b0}};
  end

  // Clear before set so a same-cycle reservation keeps the bit pending.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_int_r <= {SCALAR_REG_DEPTH{1'b0}};
      busy_fp_r  <= {SCALAR_REG_DEPTH{1'b0}};
    end else begin
      busy_int_r <= (busy_int_r & ~clr_int_s) | set_int_s;
      busy_fp_r  <= (busy_fp_r  & ~clr_fp_s)  | set_fp_s;
    end
  end

  assign issue_stall = stall_s;
  assign busy_int    = busy_int_r;
  assign busy_fp     = busy_fp_r;

`ifdef SCALAR_WB_BYPASS_EN
  // Slot 0 forwards the integer grant, slot 1 the FP grant.
  assign byp_valid   = {fp_any_s, int_any_s};
  assign byp_fp      = {fp_sel_s.fp, int_sel_s.fp};
  assign byp_rd[0]   = int_sel_s.rd;
  assign byp_rd[1]   = fp_sel_s.rd;
  assign byp_data[0] = int_sel_s.data;
  assign byp_data[1] = fp_sel_s.data;
`endif

endmodule

// File: doc/scalar_wb_arbiter.md
SCALAR_WB_ARBITER -- requirements
Module: scalar_wb_arbiter

Interface
REQ-001 SHALL have parameter NUM_SRC, default 3, meaning the number of result sources (0=ALU, 1=load, 2=FPU at default).
REQ-002 SHALL have parameter RR_EN_INIT, default 0, meaning the reset value of both round-robin pointers.
REQ-003 SHALL have port clk  input  1  clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port src_valid  input  NUM_SRC  per-source result valid.
REQ-006 SHALL have port src_fp  input  NUM_SRC  per-source target is FP file (1) or integer file (0).
REQ-007 SHALL have port src_rd  input  NUM_SRC x 5  per-source destination register index.
REQ-008 SHALL have port src_data  input  NUM_SRC x SCALAR_REG_WIDTH  per-source result data.
REQ-009 SHALL have port src_ready  output  NUM_SRC  per-source grant; a result transfers when src_valid and src_ready are both high.
REQ-010 SHALL have ports write/wr_access_ptr/write_data  output  1/5/SCALAR_REG_WIDTH  integer register file write port.
REQ-011 SHALL have ports fwrite/wr_faccess_ptr/fwrite_data  output  1/5/SCALAR_REG_WIDTH  FP register file write port.
REQ-012 SHALL have ports issue_valid/issue_fp/issue_rd  input  1/1/5  destination reservation from issue logic.
REQ-013 SHALL have port issue_stall  output  1  reservation refused because target is busy.
REQ-014 SHALL have ports busy_int/busy_fp  output  32/32  scoreboard pending-write bits.

Function
REQ-015 SHALL arbitrate integer and FP domains independently: at most one integer and one FP grant per cycle.
REQ-016 SHALL use round-robin per domain: search starts at pointer; pointer moves to winner+1 (mod NUM_SRC) on grant, unchanged otherwise.
REQ-017 SHALL compute src_ready combinationally from current valids; src_ready never high without src_valid.
REQ-018 SHALL register the granted result onto the write port: write/fwrite high exactly one cycle after the handshake, with the granted index and data; low otherwise.
REQ-019 SHALL sustain one integer and one FP writeback every cycle (register file never back-pressures).
REQ-020 SHALL, when two sources target the same domain and same index in one cycle, grant one per REQ-016; the loser retries next cycle, giving program-visible last-writer = later grant.
REQ-021 SHALL assert issue_stall combinationally when issue_valid and busy bit of (issue_fp, issue_rd) is set; stalled reservations change no state.
REQ-022 SHALL set the busy bit on an accepted reservation and clear it in the cycle write/fwrite commits that index.
REQ-023 SHALL let set win when reservation and commit target the same bit in the same cycle.
REQ-024 SHALL leave busy bits unchanged for writebacks to non-busy indices (untracked writes permitted).

Reset
REQ-025 SHALL on reset clear write, fwrite, wr_access_ptr, wr_faccess_ptr, write_data, fwrite_data, busy_int, busy_fp to 0 and set both pointers to RR_EN_INIT.
REQ-026 SHALL drop any result registered but not yet output when reset asserts mid-operation; no write pulses during or on the first cycle after reset.

Configuration
REQ-027 SHALL, with SCALAR_WB_BYPASS_EN defined, add outputs byp_valid/byp_fp/byp_rd/byp_data presenting the current-cycle granted results (integer then FP, two sets) for operand forwarding one cycle before the register file write.
REQ-028 SHALL, without SCALAR_WB_BYPASS_EN, omit those ports and logic; all other behaviour identical.

Structure
REQ-029 SHALL take SCALAR_REG_WIDTH (64), SCALAR_REG_DEPTH (32) and a wb_req_t struct (fp, rd, data) from the shared vector_chip package.
REQ-030 SHALL implement the arbiter in one sub-module rr_arbiter (NUM_SRC requests, pointer in, one-hot grant out), instantiated twice.

Verification
REQ-031 SHALL cover: src0 int rd=5 data=0xA, src2 fp rd=5 data=0xB same cycle -> both ready; next cycle write=1 ptr=5 data=0xA and fwrite=1 ptr=5 data=0xB.
REQ-032 SHALL cover: all three sources int valid continuously from reset -> grants 0,1,2,0 on consecutive cycles.
REQ-033 SHALL cover: reserve int rd=7, reissue rd=7 next cycle -> issue_stall=1, busy_int[7]=1; commit rd=7 -> busy_int[7]=0 following edge.
REQ-034 SHALL cover: reservation fp rd=3 same cycle as fwrite commit rd=3 -> busy_fp[3] stays 1.
REQ-035 SHALL cover: reset asserted one cycle after a handshake -> write stays 0, busy vectors 0.
REQ-036 SHALL cover, with SCALAR_WB_BYPASS_EN: src1 int rd=9 data=0x55 granted -> byp_valid=1, byp_rd=9, byp_data=0x55 same cycle.
